// File: rtl/tff_sync_pkg.sv
// Shared constants for the tff_sync toggle-flop bank: legal WIDTH bounds and
// the default reset image.
package tff_sync_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  localparam logic [WIDTH_MAX-1:0] DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/tff_sync_if.sv
// Toggle-enable / state bundle between a client (master drives T) and the
// tff_sync bank (slave drives Q).
interface tff_sync_if
  import tff_sync_pkg::*;
#(
  parameter int WIDTH = WIDTH_MIN
);

  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] Q;

  modport master (output T, input Q);
  modport slave  (input T, output Q);

endinterface

// File: rtl/tff_cell.sv
// Single-bit toggle flop: q inverts on each rising clk edge while t is high,
// and is forced to rst_val for as long as reset is high.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= rst_val;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

  // Reset dominates the clock; otherwise each edge applies q ^= t exactly once.
  a_resetHolds: assert property (@(posedge clk) reset |-> (q == rst_val))
    else $error("tff_cell: q not at reset value while reset is high");

  a_toggleRule: assert property (@(posedge clk) disable iff (reset)
                                 !reset |=> (q == ($past(q) ^ $past(t))))
    else $error("tff_cell: q did not follow q ^ t across a clock edge");

endmodule

// File: rtl/tff_sync.sv
// Bank of WIDTH independent toggle flops sharing one clock and one
// asynchronous active-high reset; there is no chaining between bits.
module tff_sync
  import tff_sync_pkg::*;
#(
  parameter int                   WIDTH     = 1,
  parameter logic [WIDTH_MAX-1:0] RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic        clk,
  input  logic        reset,
  tff_sync_if.slave   bus
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_badWidth
    $error("tff_sync: WIDTH %0d outside legal range %0d..%0d",
           WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  // Bits of RESET_VAL above WIDTH would be silently dropped, so reject them.
  if (WIDTH < WIDTH_MAX) begin : g_fitCheck
    if ((RESET_VAL >> WIDTH) != '0) begin : g_badResetVal
      $error("tff_sync: RESET_VAL does not fit in %0d bits", WIDTH);
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .t       (bus.T[gi]),
      .rst_val (RESET_VAL[gi]),
      .q       (bus.Q[gi])
    );
  end

endmodule

// File: tb/tb_tff_sync.sv
// Directed plus randomized checks of tff_sync at WIDTH=1 (reset 0) and
// WIDTH=4 (reset 4'b1010) against a toggle-count parity model.
module tb_tff_sync;

  localparam logic [3:0] RV4 = 4'b1010;

  logic clk = 1'b0;
  logic reset1;
  logic reset4;

  int nChecks = 0;
  int nErrors = 0;

  // The model counts accepted toggles per bit since the last reset;
  // the expected state is the reset value flipped once per odd count.
  int togCount1;
  int togCount4 [4];

  tff_sync_if #(.WIDTH(1)) bus1 ();
  tff_sync_if #(.WIDTH(4)) bus4 ();

  tff_sync #(.WIDTH(1), .RESET_VAL(64'h0)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  tff_sync #(.WIDTH(4), .RESET_VAL(64'hA)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  always #2 clk = ~clk;

  function automatic logic [3:0] model1();
    return {3'b000, (togCount1 % 2) == 1};
  endfunction

  function automatic logic [3:0] model4();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = RV4[i] ^ ((togCount4[i] % 2) == 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive T away from the edge, take one rising edge, account for toggles
  // the model accepts, then settle 1 unit past the edge.
  task automatic applyStimulus(input logic t1, input logic [3:0] t4);
    bus1.T = t1;
    bus4.T = t4;
    @(posedge clk);
    if (!reset1 && t1) togCount1++;
    for (int i = 0; i < 4; i++) begin
      if (!reset4 && t4[i]) togCount4[i]++;
    end
    #1;
  endtask

  initial begin
    togCount1 = 0;
    for (int i = 0; i < 4; i++) togCount4[i] = 0;
    reset1 = 1'b1;
    reset4 = 1'b1;
    bus1.T = 1'b0;
    bus4.T = 4'b0000;

    #1;
    checkOutput("rst1_t0", {3'b000, bus1.Q}, 4'b0000);
    checkOutput("rst4_val", bus4.Q, 4'b1010);

    // An edge during reset must not toggle even with T high.
    applyStimulus(1'b1, 4'b0110);
    checkOutput("rst1_t1_edge", {3'b000, bus1.Q}, 4'b0000);
    checkOutput("rst4_t_edge", bus4.Q, 4'b1010);

    reset1 = 1'b0;
    reset4 = 1'b0;

    applyStimulus(1'b1, 4'b0110);
    checkOutput("w1_tog1", {3'b000, bus1.Q}, 4'b0001);
    checkOutput("w4_edge1", bus4.Q, 4'b1100);
    applyStimulus(1'b1, 4'b0110);
    checkOutput("w1_tog2", {3'b000, bus1.Q}, 4'b0000);
    checkOutput("w4_edge2", bus4.Q, 4'b1010);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'b0000);
      checkOutput("w1_tog_run", {3'b000, bus1.Q}, model1());
      checkOutput("w4_hold_run", bus4.Q, 4'b1010);
    end
    checkOutput("w1_after6", {3'b000, bus1.Q}, 4'b0000);

    applyStimulus(1'b1, 4'b0000);
    checkOutput("w1_tog7", {3'b000, bus1.Q}, 4'b0001);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("w1_hold", {3'b000, bus1.Q}, 4'b0001);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("w1_resume", {3'b000, bus1.Q}, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("w1_high_again", {3'b000, bus1.Q}, 4'b0001);

    // Glitches on T between edges must not reach Q.
    bus1.T = 1'b0;
    #1;
    bus1.T = 1'b1;
    checkOutput("w1_glitch", {3'b000, bus1.Q}, 4'b0001);

    // Mid-cycle reset assertion clears Q before the next edge.
    @(posedge clk);
    togCount1++;
    #1;
    checkOutput("w1_pre_rst", {3'b000, bus1.Q}, model1());
    bus1.T = 1'b1;
    reset1 = 1'b1;
    togCount1 = 0;
    #1;
    checkOutput("w1_async_rst", {3'b000, bus1.Q}, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("w1_rst_hold", {3'b000, bus1.Q}, 4'b0000);

    // Deassert exactly at the edge; the NBA makes the DUT see reset still high there.
    bus1.T = 1'b1;
    @(posedge clk);
    reset1 <= 1'b0;
    #1;
    checkOutput("w1_coincident_rel", {3'b000, bus1.Q}, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("w1_first_tog", {3'b000, bus1.Q}, 4'b0001);

    // Randomized phase with one mid-run reset pulse on the 4-bit bank.
    for (int n = 0; n < 40; n++) begin
      if (n == 20) begin
        reset4 = 1'b1;
        for (int i = 0; i < 4; i++) togCount4[i] = 0;
        #1;
        checkOutput("w4_rand_rst", bus4.Q, 4'b1010);
      end
      if (n == 22) reset4 = 1'b0;
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom));
      checkOutput("w1_rand", {3'b000, bus1.Q}, model1());
      checkOutput("w4_rand", bus4.Q, model4());
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
